lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the data-memory wrapper. Sits between the execute stage and the memory, handling one request at a time.
- Accepts one CPU memory request through a valid/ready handshake and checks alignment.
- Drives the memory wrapper port (byte address, write data, write enable, size) for exactly one cycle per legal access.
- Sign- or zero-extends the lane-aligned, zero-extended load data returned by the wrapper and presents the result through a response handshake.

Parameters:
- ADDR_W, 32, width of the byte address.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for sub-word stores.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_err  out  1  access was misaligned or had an illegal size.
- mem_addr  out  32  byte address to the memory wrapper.
- mem_wr_data  out  32  store data to the wrapper, unshifted.
- mem_wr_en  out  1  write strobe.
- mem_size  out  2  size to the wrapper.
- mem_rd_data  in  32  zero-extended lane data from the wrapper. Synchronous read: valid the cycle after the address is driven.
- perf_loads, perf_stores, perf_faults  out  32 each  event counters (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All request and response registers cleared.
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_wr_en=0, mem_addr=0, mem_wr_data=0, mem_size=0.
  - Counters=0.
  - Reset mid-operation aborts the access. A store already in ISSUE may or may not have been written.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - Accept when req_valid=1 at a clock edge (cycle T).
  - On acceptance, register addr, wdata, we, size and unsigned.
- Alignment check, evaluated at acceptance:
  - Fault if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - Fault path goes IDLE->RESP: resp_valid=1 in T+1, resp_err=1, resp_rdata=0.
  - No memory access occurs; mem_wr_en never asserts.
- Legal access goes IDLE->ISSUE (T+1):
  - mem_addr, mem_size and mem_wr_data are driven from the registers.
  - mem_wr_en = registered we, asserted only in this cycle.
- Store completes ISSUE->RESP:
  - resp_valid=1 in T+2, resp_err=0, resp_rdata=0.
- Load goes ISSUE->CAPTURE (T+2):
  - mem_rd_data is valid in this cycle.
  - The extended value is registered into resp_rdata.
  - Byte: bit 7 replicated into [31:8] when signed.
  - Halfword: bit 15 replicated into [31:16] when signed.
  - Word: passed through unchanged.
  - Unsigned: upper bits zero.
- CAPTURE->RESP: resp_valid=1 in T+3.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1.
  - On resp_ready=1 at the edge, go to IDLE and drop resp_valid.
  - Stalls of any length are legal.
- Latencies with resp_ready held at 1: load 3 cycles, store 2 cycles, fault 1 cycle.
- Next request accepted at earliest the cycle after the response handshake. There is no back-to-back overlap; exactly one request is outstanding.
- mem_addr, mem_size and mem_wr_data hold their last values outside ISSUE/CAPTURE.
- mem_wr_en is 0 in every state except ISSUE on a store.
- req_valid while not in IDLE is ignored. The requester must hold the request until req_ready.
- resp_ready while resp_valid=0 is ignored.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined:
  - perf_loads increments on each accepted legal load.
  - perf_stores increments on each accepted legal store.
  - perf_faults increments on each accepted faulting request.
  - All counters are 32-bit, wrap 0xFFFFFFFF->0, and are cleared by rst.
- Undefined: the three perf outputs are tied to 0 and no counter flops are built.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=10.
  - Expect mem_wr_en=1 for exactly one cycle (T+1) and resp_valid at T+2.
  - Then load 0x10: expect resp_rdata=0xDEADBEEF at T+3.
- Byte sign/zero extension: memory returns 0x00000080 for a byte load at 0x13.
  - Signed: expect resp_rdata=0xFFFFFF80.
  - Unsigned: expect 0x00000080.
- Halfword sign extension: memory returns 0x0000F00D for a signed halfword load at 0x22. Expect 0xFFFFF00D.
- Misaligned accesses: word load at 0x6, halfword store at 0x9, and size=11 at 0x0.
  - Expect resp_err=1 at T+1 and resp_rdata=0.
  - Expect mem_wr_en stays 0 throughout.
- Response backpressure: hold resp_ready=0 for 5 cycles after a load of 0x12345678.
  - Expect resp_valid and resp_rdata stable for all 5 cycles and req_ready=0.
  - Release resp_ready: expect the block in IDLE and req_ready=1 the next cycle.
- Reset mid-access: assert rst asynchronously in CAPTURE.
  - Expect resp_valid=0, mem_wr_en=0 and req_ready=1 immediately.
  - With LSU_PERF_CNT_EN defined, expect all counters=0.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bundle of request, response and memory-wrapper signals for the load/store control stage.
// slave = the lsu_ctrl side, master = the execute stage / memory environment side.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_en;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned,
        input  resp_ready, mem_rd_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wr_data, mem_wr_en, mem_size
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned,
        output resp_ready, mem_rd_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wr_data, mem_wr_en, mem_size
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store control stage: alignment check, one-cycle memory issue, load extension.
// Optional event counters are built only when LSU_PERF_CNT_EN is defined.
module lsu_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    lsu_ctrl_if.slave   bus,
    output logic [31:0] perf_loads,
    output logic [31:0] perf_stores,
    output logic [31:0] perf_faults
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state_q;
    logic              we_q;
    logic              uns_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        mem_size_q;
    logic              mem_wr_en_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [DATA_W-1:0] resp_rdata_d;
    logic              req_fault;
    logic              accept;

    // The wrapper already zero-extends its lane, so only the upper fill needs choosing.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] raw,
                                                      input logic [1:0] size,
                                                      input logic uns);
        case (size)
            2'b00:   return uns ? {{(DATA_W-8){1'b0}}, raw[7:0]}
                                : {{(DATA_W-8){raw[7]}}, raw[7:0]};
            2'b01:   return uns ? {{(DATA_W-16){1'b0}}, raw[15:0]}
                                : {{(DATA_W-16){raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign req_fault = (bus.req_size == 2'b11) ||
                       ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign accept       = (state_q == IDLE) && bus.req_valid;
    assign resp_rdata_d = extend_load(bus.mem_rd_data, mem_size_q, uns_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
            mem_wr_en_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q  <= bus.req_we;
                        uns_q <= bus.req_unsigned;
                        if (req_fault) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            // Memory port is loaded at acceptance so it is live during ISSUE.
                            state_q     <= ISSUE;
                            mem_addr_q  <= bus.req_addr;
                            mem_wdata_q <= bus.req_wdata;
                            mem_size_q  <= bus.req_size;
                            mem_wr_en_q <= bus.req_we;
                        end
                    end
                end
                ISSUE: begin
                    mem_wr_en_q <= 1'b0;
                    if (we_q) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= resp_rdata_d;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wdata_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_size    = mem_size_q;

`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads_q;
    logic [31:0] perf_stores_q;
    logic [31:0] perf_faults_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_loads_q  <= '0;
            perf_stores_q <= '0;
            perf_faults_q <= '0;
        end else if (accept) begin
            if (req_fault)       perf_faults_q <= perf_faults_q + 32'd1;
            else if (bus.req_we) perf_stores_q <= perf_stores_q + 32'd1;
            else                 perf_loads_q  <= perf_loads_q + 32'd1;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
    assign perf_faults = perf_faults_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign perf_loads    = '0;
    assign perf_stores   = '0;
    assign perf_faults   = '0;
`endif
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed plus randomized bench for lsu_ctrl with a byte-array reference model and a synchronous-read memory wrapper.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] perf_loads, perf_stores, perf_faults;

    int checks = 0;
    int errors = 0;

`ifdef LSU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    int unsigned exp_loads = 0, exp_stores = 0, exp_faults = 0;

    lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .perf_loads  (perf_loads),
        .perf_stores (perf_stores),
        .perf_faults (perf_faults)
    );

    always #5 clk = ~clk;

    // Memory wrapper: byte-addressed, little-endian, zero-extended synchronous read.
    logic [7:0] wmem [0:255] = '{default: 8'h00};
    always @(posedge clk) begin
        logic [7:0] a;
        logic [31:0] rd;
        int n;
        a = bus_if.mem_addr[7:0];
        n = (bus_if.mem_size == 2'b00) ? 1 : (bus_if.mem_size == 2'b01) ? 2 : 4;
        rd = 32'h0;
        for (int i = 0; i < n; i++) rd = rd | (32'(wmem[8'(a + 8'(i))]) << (8 * i));
        bus_if.mem_rd_data <= rd;
        if (bus_if.mem_wr_en)
            for (int i = 0; i < n; i++) wmem[8'(a + 8'(i))] <= bus_if.mem_wr_data[8*i +: 8];
    end

    // Reference memory, updated from the requests the model accepts.
    logic [7:0] rmem [0:255] = '{default: 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf();
        chk("perf_loads",  perf_loads,  PERF ? exp_loads  : 32'd0);
        chk("perf_stores", perf_stores, PERF ? exp_stores : 32'd0);
        chk("perf_faults", perf_faults, PERF ? exp_faults : 32'd0);
    endtask

    // Issue one request from a negedge and follow it through the response handshake.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                          input logic [1:0] sz, input logic uns, input int stall);
        logic fault;
        int n, lat_exp, cyc, wr_cnt;
        logic [31:0] exp_rd, val;

        fault = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        exp_rd = 32'h0;
        if (!fault && !we) begin
            val = 32'h0;
            for (int i = 0; i < n; i++) val = val + (32'(rmem[8'(a[7:0] + 8'(i))]) << (8 * i));
            if (!uns && n < 4 && val[8*n-1]) val = val - (32'd1 << (8 * n));
            exp_rd = val;
        end
        lat_exp = fault ? 1 : (we ? 2 : 3);

        cyc = 0;
        while (!bus_if.req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("req_ready_before_req", 32'(bus_if.req_ready), 32'd1);

        bus_if.req_addr     = a;
        bus_if.req_wdata    = wd;
        bus_if.req_we       = we;
        bus_if.req_size     = sz;
        bus_if.req_unsigned = uns;
        bus_if.req_valid    = 1'b1;
        bus_if.resp_ready   = (stall == 0);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.req_wdata = $urandom;

        cyc = 1;
        wr_cnt = 0;
        forever begin
            if (bus_if.mem_wr_en) wr_cnt++;
            if (cyc == 1 && !fault) begin
                chk("issue_mem_addr",  bus_if.mem_addr, a);
                chk("issue_mem_size",  32'(bus_if.mem_size), 32'(sz));
                chk("issue_mem_wdata", bus_if.mem_wr_data, wd);
                chk("issue_mem_wr_en", 32'(bus_if.mem_wr_en), 32'(we));
            end
            if (bus_if.resp_valid || cyc >= 10) break;
            @(negedge clk);
            cyc++;
        end
        chk("resp_latency", 32'(cyc), 32'(lat_exp));
        chk("wr_en_cycles", 32'(wr_cnt), (!fault && we) ? 32'd1 : 32'd0);
        chk("resp_err",     32'(bus_if.resp_err), 32'(fault));
        chk("resp_rdata",   bus_if.resp_rdata, exp_rd);
        chk("req_ready_busy", 32'(bus_if.req_ready), 32'd0);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_resp_valid", 32'(bus_if.resp_valid), 32'd1);
            chk("stall_resp_rdata", bus_if.resp_rdata, exp_rd);
            chk("stall_resp_err",   32'(bus_if.resp_err), 32'(fault));
            chk("stall_req_ready",  32'(bus_if.req_ready), 32'd0);
            chk("stall_mem_wr_en",  32'(bus_if.mem_wr_en), 32'd0);
        end
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        bus_if.resp_ready = 1'b0;
        chk("post_hs_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        chk("post_hs_req_ready",  32'(bus_if.req_ready), 32'd1);

        if (fault) exp_faults++;
        else if (we) begin
            exp_stores++;
            for (int i = 0; i < n; i++) rmem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
        end else exp_loads++;
        chk_perf();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req_ready"},   32'(bus_if.req_ready), 32'd1);
        chk({tag, "_resp_valid"},  32'(bus_if.resp_valid), 32'd0);
        chk({tag, "_resp_err"},    32'(bus_if.resp_err), 32'd0);
        chk({tag, "_resp_rdata"},  bus_if.resp_rdata, 32'd0);
        chk({tag, "_mem_wr_en"},   32'(bus_if.mem_wr_en), 32'd0);
        chk({tag, "_mem_addr"},    bus_if.mem_addr, 32'd0);
        chk({tag, "_mem_wr_data"}, bus_if.mem_wr_data, 32'd0);
        chk({tag, "_mem_size"},    32'(bus_if.mem_size), 32'd0);
        chk_perf();
    endtask

    initial begin
        bus_if.req_valid    = 1'b0;
        bus_if.req_addr     = 32'h0;
        bus_if.req_wdata    = 32'h0;
        bus_if.req_we       = 1'b0;
        bus_if.req_size     = 2'b00;
        bus_if.req_unsigned = 1'b0;
        bus_if.resp_ready   = 1'b0;

        #2;
        chk_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Word store then load.
        do_req(32'h10, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, 0);
        do_req(32'h10, 32'h0,        1'b0, 2'b10, 1'b0, 0);
        // Byte extension: byte 0x13 holds 0x80.
        do_req(32'h13, 32'h00000080, 1'b1, 2'b00, 1'b0, 0);
        do_req(32'h13, 32'h0,        1'b0, 2'b00, 1'b0, 0);
        do_req(32'h13, 32'h0,        1'b0, 2'b00, 1'b1, 0);
        // Halfword extension: halfword 0x22 holds 0xF00D.
        do_req(32'h22, 32'h1234F00D, 1'b1, 2'b01, 1'b0, 0);
        do_req(32'h22, 32'h0,        1'b0, 2'b01, 1'b0, 0);
        do_req(32'h22, 32'h0,        1'b0, 2'b01, 1'b1, 0);
        // Faulting accesses.
        do_req(32'h6,  32'h0,        1'b0, 2'b10, 1'b0, 0);
        do_req(32'h9,  32'hCAFEBABE, 1'b1, 2'b01, 1'b0, 0);
        do_req(32'h0,  32'h0,        1'b0, 2'b11, 1'b0, 0);
        do_req(32'h0,  32'h55AA55AA, 1'b1, 2'b11, 1'b0, 2);
        // Backpressure on a load.
        do_req(32'h40, 32'h12345678, 1'b1, 2'b10, 1'b0, 0);
        do_req(32'h40, 32'h0,        1'b0, 2'b10, 1'b0, 5);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra;
            ra = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 32'hEF));
            do_req(ra, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while a load sits in CAPTURE.
        bus_if.req_addr     = 32'h10;
        bus_if.req_we       = 1'b0;
        bus_if.req_size     = 2'b10;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_valid    = 1'b1;
        bus_if.resp_ready   = 1'b1;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        exp_loads = 0;
        exp_stores = 0;
        exp_faults = 0;
        #1;
        chk_reset_state("midreset");
        bus_if.resp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_req(32'h40, 32'h0, 1'b0, 2'b00, 1'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
